if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline, sitting directly upstream of decode and immediate generation.
- Owns the PC register and runs a req/ack handshake to instruction memory with variable latency.
- Presents a registered IF/ID bundle (valid, instruction, PC, PC+4) that decode and the immediate generator consume.
- Accepts stall from the hazard unit and redirect (taken branch/jump) from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in ifid_instr on reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request; held high until acked.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- imem_ack  in  1  one-cycle completion pulse; may come in the same cycle req rises.
- stall  in  1  hold the IF/ID outputs.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  target; bits [1:0] are forced to 0 internally.
- ifid_valid  out  1  IF/ID bundle holds a real instruction.
- ifid_instr  out  32  fetched instruction.
- ifid_pc  out  32  address of ifid_instr.
- ifid_pc_plus4  out  32  ifid_pc+4, wraps mod 2^32.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=FETCH, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0, pend_pc=0, skid=0.
  - imem_req is gated to 0 while rst=1.
  - Reset mid-transaction abandons any outstanding request; the memory is reset on the same rst.
- State FETCH: imem_req=1, imem_addr=pc.
  - ack=1, redirect=0, stall=0: IF/ID <= {1, rdata, pc, pc+4}; pc<=pc+4. Back-to-back acks give 1 instruction/cycle.
  - ack=1, redirect=0, stall=1: skid<={rdata,pc}; pc<=pc+4; go to HOLD. IF/ID unchanged.
  - ack=0, redirect=0, stall=0: ifid_valid<=0 (bubble). Other IF/ID fields hold.
  - ack=0, redirect=0, stall=1: IF/ID holds.
  - redirect=1, ack=1: data discarded; pc<=redirect_pc; stay FETCH.
  - redirect=1, ack=0: pend_pc<=redirect_pc; go to DROP, because the request cannot be withdrawn.
- State HOLD: imem_req=0.
  - stall=0: IF/ID <= {1, skid}; go to FETCH.
  - redirect=1: skid discarded; pc<=redirect_pc; go to FETCH.
- State DROP: imem_req=1, imem_addr=old pc (unchanged).
  - ack=1: data discarded; pc<=pend_pc; go to FETCH.
  - Another redirect while in DROP overwrites pend_pc (latest wins).
  - If redirect and ack coincide in DROP: pc<=new redirect_pc.
- Flush:
  - Any cycle with redirect=1 forces ifid_valid<=0 and ifid_instr<=NOP_INSTR.
  - Redirect has priority over stall.
- In every state, a cycle with stall=1 and redirect=0 leaves all ifid_* outputs unchanged.
- Arithmetic:
  - pc+4 wraps from 32'hFFFF_FFFC to 0.
  - ifid_pc_plus4 is computed from the captured PC, never from the live pc.
- imem_ack is ignored when imem_req=0 (HOLD state, or reset).
- Latency: request issued in cycle N with ack in cycle N+k gives ifid_valid=1 in cycle N+k+1.

Test Plan:
- Reset then zero-latency memory (ack tied to req, rdata=addr^32'hA5A5_0000): ifid_pc sequence 0,4,8,12 on consecutive cycles, all valid, ifid_pc_plus4=ifid_pc+4.
- Memory latency 3: ifid_valid pulses once every 4 cycles with bubbles in between. imem_addr stays stable while req is high.
- stall asserted on the cycle of ack for pc=8: IF/ID holds the pc=4 bundle, imem_req=0 during the stall. On stall release, ifid_pc=8 next cycle, then fetch resumes at 12.
- redirect to 32'h0000_0103 while a latency-3 request to 16 is outstanding:
  - imem_req stays high at addr 16 until ack, and that data never appears.
  - Next request address is 0x100; ifid_valid=0 with NOP until 0x100 is delivered.
  - A second redirect to 0x200 inside the DROP window means 0x200 is fetched instead.
- RESET_PC=32'hFFFF_FFF8, zero latency: PCs FFFF_FFF8, FFFF_FFFC, 0. ifid_pc_plus4 for FFFF_FFFC is 0.
- rst asserted during DROP: next cycle pc=RESET_PC, ifid_valid=0, imem_req=0 while rst is high, then a fetch at RESET_PC.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bundle between the fetch stage and imem.
// The master drives the request and the address. The slave returns the data and the ack pulse.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage. It owns the PC and runs a variable-latency req/ack fetch.
// It presents a registered IF/ID bundle, with stall skid buffering and redirect flush.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    if_stage_if.master         imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               ifid_valid,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pc,
    output logic [31:0]        ifid_pc_plus4
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] redir_tgt;

    assign redir_tgt      = {redirect_pc[31:2], 2'b00};
    assign imem.imem_req  = ~rst & (state_q != HOLD);
    assign imem.imem_addr = pc_q;

    assign ifid_valid    = ifid_valid_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_pc_d       = pend_pc_q;
        skid_instr_d    = skid_instr_q;
        skid_pc_d       = skid_pc_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;

        if (redirect) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    // An unacked request cannot be withdrawn, so park the target until it completes.
                    if (imem.imem_ack) begin
                        pc_d = redir_tgt;
                    end else begin
                        pend_pc_d = redir_tgt;
                        state_d   = DROP;
                    end
                end else if (imem.imem_ack) begin
                    pc_d = pc_q + 32'd4;
                    if (stall) begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = HOLD;
                    end else begin
                        ifid_valid_d    = 1'b1;
                        ifid_instr_d    = imem.imem_rdata;
                        ifid_pc_d       = pc_q;
                        ifid_pc_plus4_d = pc_q + 32'd4;
                    end
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redir_tgt;
                    state_d = FETCH;
                end else if (!stall) begin
                    ifid_valid_d    = 1'b1;
                    ifid_instr_d    = skid_instr_q;
                    ifid_pc_d       = skid_pc_q;
                    ifid_pc_plus4_d = skid_pc_q + 32'd4;
                    state_d         = FETCH;
                end
            end
            DROP: begin
                if (imem.imem_ack) begin
                    pc_d    = redirect ? redir_tgt : pend_pc_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    pend_pc_d = redir_tgt;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= FETCH;
            pc_q            <= RESET_PC;
            pend_pc_q       <= 32'd0;
            skid_instr_q    <= 32'd0;
            skid_pc_q       <= 32'd0;
            ifid_valid_q    <= 1'b0;
            ifid_instr_q    <= NOP_INSTR;
            ifid_pc_q       <= 32'd0;
            ifid_pc_plus4_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pend_pc_q       <= pend_pc_d;
            skid_instr_q    <= skid_instr_d;
            skid_pc_q       <= skid_pc_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a transaction-level fetch model predicts imem and IF/ID each cycle.
// A second instance with a high reset PC exercises PC wrap-around.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } skid_t;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        tb_ack;
    logic [31:0] tb_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;

    logic        rst2;
    logic        ifid_valid2;
    logic [31:0] ifid_instr2, ifid_pc2, ifid_pc_plus4_2;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, d_tgt;
    logic        m_v, discard;
    skid_t       skid_q[$];
    int          mem_cnt, mem_lat;

    if_stage_if mif ();
    if_stage_if mif2 ();

    assign mif.imem_ack    = tb_ack;
    assign mif.imem_rdata  = tb_rdata;
    assign mif2.imem_ack   = mif2.imem_req;
    assign mif2.imem_rdata = mif2.imem_addr ^ 32'hA5A5_0000;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .imem(mif.master),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst2), .imem(mif2.master),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'd0),
        .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2),
        .ifid_pc(ifid_pc2), .ifid_pc_plus4(ifid_pc_plus4_2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick_lat(input int lat_mode);
        return (lat_mode >= 0) ? lat_mode : $urandom_range(0, 3);
    endfunction

    task automatic model_reset(input int lat_mode);
        m_pc    = 32'd0;
        discard = 1'b0;
        skid_q.delete();
        m_v     = 1'b0;
        m_instr = NOP;
        m_ipc   = 32'd0;
        m_ipc4  = 32'd0;
        mem_cnt = 0;
        mem_lat = pick_lat(lat_mode);
    endtask

    // One clock: drive at the falling edge, check, then advance the model past the next rising edge.
    task automatic cycle(input int lat_mode, input int p_stall, input int p_redir, input int p_rst);
        logic        exp_req, acc;
        logic [31:0] tgt;
        skid_t       s;
        @(negedge clk);
        rst      = ($urandom_range(0, 99) < p_rst);
        stall    = ($urandom_range(0, 99) < p_stall);
        redirect = ($urandom_range(0, 99) < p_redir);
        redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
        exp_req  = !rst && (skid_q.size() == 0);
        // the memory completes after mem_lat cycles; stray acks while idle must be ignored
        tb_ack   = exp_req ? (mem_cnt >= mem_lat) : ($urandom_range(0, 3) == 0);
        tb_rdata = m_pc ^ 32'hA5A5_0000;
        #1;
        check("imem_req", {31'd0, mif.imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", mif.imem_addr, m_pc);
        check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
        check("ifid_instr", ifid_instr, m_instr);
        check("ifid_pc", ifid_pc, m_ipc);
        check("ifid_pc_plus4", ifid_pc_plus4, m_ipc4);

        if (rst) begin
            model_reset(lat_mode);
        end else begin
            acc = tb_ack && exp_req;
            tgt = redirect_pc & ~32'h3;
            if (redirect) begin
                m_v     = 1'b0;
                m_instr = NOP;
                if (skid_q.size() != 0) begin
                    skid_q.delete();
                    m_pc = tgt;
                end else if (acc) begin
                    m_pc    = tgt;
                    discard = 1'b0;
                end else begin
                    discard = 1'b1;
                    d_tgt   = tgt;
                end
            end else if (skid_q.size() != 0) begin
                if (!stall) begin
                    s = skid_q.pop_front();
                    m_v = 1'b1; m_instr = s.instr; m_ipc = s.pc; m_ipc4 = s.pc + 32'd4;
                end
            end else if (discard) begin
                if (acc) begin
                    m_pc    = d_tgt;
                    discard = 1'b0;
                end
            end else if (acc) begin
                if (stall) skid_q.push_back(skid_t'{instr: tb_rdata, pc: m_pc});
                else begin
                    m_v = 1'b1; m_instr = tb_rdata; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
                end
                m_pc = m_pc + 32'd4;
            end else if (!stall) begin
                m_v = 1'b0;
            end
            if (exp_req) begin
                if (tb_ack) begin
                    mem_cnt = 0;
                    mem_lat = pick_lat(lat_mode);
                end else begin
                    mem_cnt++;
                end
            end
        end
    endtask

    task automatic run(input int n, input int lat_mode, input int p_stall, input int p_redir, input int p_rst);
        for (int i = 0; i < n; i++) cycle(lat_mode, p_stall, p_redir, p_rst);
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        tb_ack = 1'b0; tb_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1 check("wrap_req_in_reset", {31'd0, mif2.imem_req}, 32'd0);
        rst2 = 1'b0;
        @(negedge clk);
        #1 check("wrap_pc0", ifid_pc2, 32'hFFFF_FFF8);
        check("wrap_pc0_plus4", ifid_pc_plus4_2, 32'hFFFF_FFFC);
        check("wrap_valid0", {31'd0, ifid_valid2}, 32'd1);
        @(negedge clk);
        #1 check("wrap_pc1", ifid_pc2, 32'hFFFF_FFFC);
        check("wrap_pc1_plus4", ifid_pc_plus4_2, 32'd0);
        check("wrap_instr1", ifid_instr2, 32'hFFFF_FFFC ^ 32'hA5A5_0000);
        @(negedge clk);
        #1 check("wrap_pc2", ifid_pc2, 32'd0);
        check("wrap_pc2_plus4", ifid_pc_plus4_2, 32'd4);

        model_reset(0);
        run(2,    0,  0,  0, 100);  // reset state
        run(12,   0,  0,  0, 0);    // zero-latency streaming
        run(20,   3,  0,  0, 0);    // fixed latency 3
        run(40,   3,  0, 15, 0);    // redirects while requests are outstanding
        run(40,   0, 40,  0, 0);    // stalls with back-to-back acks
        run(3000, -1, 30, 10, 3);   // mixed random traffic
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
